up_down_counter: RTL and testbench

- Parameterised N-bit synchronous binary up/down counter with active-low count enable, active-low synchronous parallel load, and active-low ripple-carry output.
- Modelled on the 74x191 counter.
- Used as a building block for counter chains: the rco_b of one stage feeds the en_b of the next.

---
 rtl/up_down_counter_pkg.sv | 33 +++
 rtl/up_down_counter.sv | 72 +++++++
 tb/tb_up_down_counter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/up_down_counter_pkg.sv
// -----------------------------------------------------------------------------
// up_down_counter_pkg
//   Shared definitions for the up/down counter.
//   - cnt_op_e  : the action the counter takes on the next rising clock edge
//   - decode_op : maps the active-low control pins onto that action. Load
//                 outranks counting, and counting outranks hold.
// -----------------------------------------------------------------------------
package up_down_counter_pkg;

    typedef enum logic [1:0] {
        CNT_HOLD = 2'b00,
        CNT_LOAD = 2'b01,
        CNT_UP   = 2'b10,
        CNT_DOWN = 2'b11
    } cnt_op_e;

    function automatic cnt_op_e decode_op(
        input logic load_b,
        input logic en_b,
        input logic up
    );
        cnt_op_e op;
        if (!load_b) begin
            op = CNT_LOAD;
        end else if (!en_b) begin
            op = up ? CNT_UP : CNT_DOWN;
        end else begin
            op = CNT_HOLD;
        end
        return op;
    endfunction

endpackage

// File: rtl/up_down_counter.sv
// -----------------------------------------------------------------------------
// up_down_counter
//   N-bit synchronous binary up/down counter in the style of the 74x191.
//   Several stages can be chained by feeding the rco_b of one stage into the
//   en_b of the next.
//
// Parameters
//   N        counter width in bits (N >= 1)
//
// Ports
//   clk      in   rising-edge clock
//   rst_b    in   asynchronous active-low reset; forces q to 0
//   en_b     in   active-low count enable
//   load_b   in   active-low synchronous parallel load; ignores en_b and up
//   up       in   count direction: 1 counts up, 0 counts down
//   load_in  in   [N] parallel load value
//   q        out  [N] registered counter value
//   rco_b    out  active-low ripple carry/borrow. This output is
//                 combinational from en_b, up and q.
// -----------------------------------------------------------------------------
module up_down_counter
    import up_down_counter_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         en_b,
    input  logic         load_b,
    input  logic         up,
    input  logic [N-1:0] load_in,
    output logic [N-1:0] q,
    output logic         rco_b
);

    logic [N-1:0] r_q;
    cnt_op_e      w_op;
    logic         w_tc;

    assign w_op = decode_op(load_b, en_b, up);

    // load_in is only sampled on the load path. An unknown load_in therefore
    // cannot reach q while load_b is high.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_q <= '0;
        end else begin
            case (w_op)
                CNT_LOAD: r_q <= load_in;
                CNT_UP:   r_q <= r_q + 1'b1;   // all ones wraps to zero
                CNT_DOWN: r_q <= r_q - 1'b1;   // zero wraps to all ones
                default:  r_q <= r_q;
            endcase
        end
    end

    // The terminal count depends on the direction currently selected.
    // rco_b therefore follows changes on up and en_b within the same cycle.
    always_comb begin
        w_tc  = 1'b0;
        rco_b = 1'b1;
        if (up) begin
            w_tc = &r_q;
        end else begin
            w_tc = ~(|r_q);
        end
        rco_b = ~(~en_b & w_tc);
    end

    assign q = r_q;

endmodule

// File: tb/tb_up_down_counter.sv
// -----------------------------------------------------------------------------
// tb_up_down_counter
//   Directed bench for up_down_counter. It drives a 4-bit instance and a
//   5-bit instance from the same control pins.
// -----------------------------------------------------------------------------
module tb_up_down_counter;

    logic       clk;
    logic       rst_b;
    logic       en_b;
    logic       load_b;
    logic       up;
    logic [3:0] load_in4;
    logic [4:0] load_in5;
    logic [3:0] q4;
    logic [4:0] q5;
    logic       rco4;
    logic       rco5;

    int checks   = 0;
    int failures = 0;

    up_down_counter #(.N(4)) u_cnt4 (
        .clk     (clk),
        .rst_b   (rst_b),
        .en_b    (en_b),
        .load_b  (load_b),
        .up      (up),
        .load_in (load_in4),
        .q       (q4),
        .rco_b   (rco4)
    );

    up_down_counter #(.N(5)) u_cnt5 (
        .clk     (clk),
        .rst_b   (rst_b),
        .en_b    (en_b),
        .load_b  (load_b),
        .up      (up),
        .load_in (load_in5),
        .q       (q5),
        .rco_b   (rco5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    // Advance to just past the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_b    = 1'b0;
        en_b     = 1'b1;
        load_b   = 1'b1;
        up       = 1'b1;
        load_in4 = 4'h0;
        load_in5 = 5'h00;

        // Reset state
        #12;
        check_val("rst_q4", 32'(q4), 32'h0);
        check_val("rst_q5", 32'(q5), 32'h00);
        check_val("rst_rco4_en_off", 32'(rco4), 32'h1);
        en_b = 1'b0; up = 1'b0; #1;
        check_val("rst_rco4_down_en", 32'(rco4), 32'h0);
        check_val("rst_rco5_down_en", 32'(rco5), 32'h0);
        en_b = 1'b1; up = 1'b1;

        // Release reset, then load zero with the count disabled
        #2; rst_b = 1'b1;
        load_b = 1'b0;
        step();
        check_val("load0_q4", 32'(q4), 32'h0);
        check_val("load0_q5", 32'(q5), 32'h0);

        // Up count over 32 edges
        load_b = 1'b1; up = 1'b1; en_b = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            step();
            check_val($sformatf("up_q4_%0d", i), 32'(q4), 32'(i % 16));
            check_val($sformatf("up_q5_%0d", i), 32'(q5), 32'(i % 32));
            check_val($sformatf("up_rco4_%0d", i), 32'(rco4), (i % 16 == 15) ? 32'h0 : 32'h1);
            check_val($sformatf("up_rco5_%0d", i), 32'(rco5), (i % 32 == 31) ? 32'h0 : 32'h1);
        end

        // Down count: load all ones, then count down
        up = 1'b0; en_b = 1'b1; load_b = 1'b0;
        load_in4 = 4'hF; load_in5 = 5'h1F;
        step();
        check_val("dn_load_q4", 32'(q4), 32'hF);
        check_val("dn_load_q5", 32'(q5), 32'h1F);
        en_b = 1'b0; load_b = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step();
            check_val($sformatf("dn_q4_%0d", i), 32'(q4), 32'((15 - i) & 15));
            check_val($sformatf("dn_q5_%0d", i), 32'(q5), 32'(31 - i));
            check_val($sformatf("dn_rco4_%0d", i), 32'(rco4), (i == 15) ? 32'h0 : 32'h1);
            check_val($sformatf("dn_rco5_%0d", i), 32'(rco5), 32'h1);
            if (i == 15) begin
                // The carry output should drop out as soon as the enable goes away.
                en_b = 1'b1; #1;
                check_val("dn_rco4_en_off", 32'(rco4), 32'h1);
                en_b = 1'b0;
            end
        end

        // Hold at a terminal value (q4 = F with up = 1)
        up = 1'b1; en_b = 1'b1; #1;
        check_val("hold_rco4_terminal", 32'(rco4), 32'h1);
        for (int i = 0; i < 3; i++) begin
            step();
            check_val($sformatf("hold_q4_%0d", i), 32'(q4), 32'hF);
            check_val($sformatf("hold_q5_%0d", i), 32'(q5), 32'hF);
        end

        // Load priority while the count is disabled, then one down step
        up = 1'b0; load_b = 1'b0; en_b = 1'b1;
        load_in4 = 4'b1010; load_in5 = 5'b01010;
        step();
        check_val("ld_q4", 32'(q4), 32'hA);
        check_val("ld_q5", 32'(q5), 32'h0A);
        load_b = 1'b1; en_b = 1'b0;
        step();
        check_val("ld_dn_q4", 32'(q4), 32'h9);
        check_val("ld_dn_q5", 32'(q5), 32'h09);

        // Switch to up, load while enabled, then one up step
        up = 1'b1; load_b = 1'b0;
        load_in4 = 4'b0101; load_in5 = 5'b10101;
        step();
        check_val("ld_up_q4", 32'(q4), 32'h5);
        check_val("ld_up_q5", 32'(q5), 32'h15);
        load_b = 1'b1;
        step();
        check_val("up_after_ld_q4", 32'(q4), 32'h6);
        check_val("up_after_ld_q5", 32'(q5), 32'h16);

        // Load to a terminal value: rco_b asserts in the cycle after the load edge
        load_b = 1'b0; load_in4 = 4'hF; load_in5 = 5'h1F;
        step();
        check_val("ld_term_q4", 32'(q4), 32'hF);
        check_val("ld_term_rco4", 32'(rco4), 32'h0);
        check_val("ld_term_rco5", 32'(rco5), 32'h0);

        // Asynchronous reset in the middle of the count
        load_in4 = 4'h7; load_in5 = 5'h07;
        step();
        check_val("pre_rst_q4", 32'(q4), 32'h7);
        load_b = 1'b1;
        #3; rst_b = 1'b0; #1;
        check_val("async_rst_q4", 32'(q4), 32'h0);
        check_val("async_rst_q5", 32'(q5), 32'h0);
        step();
        rst_b = 1'b1;
        step();
        check_val("resume_q4", 32'(q4), 32'h1);
        check_val("resume_q5", 32'(q5), 32'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
